column_count_accum: RTL and testbench
=====================================

Name: column_count_accum

Overview:
- Parametrised, pipelined successor to the team's fixed 5-input ones counter used in partial-product column reduction.
- Counts the ones in an N-bit column vector plus a carry-in bit.
- Mode 0 (single): emits one count per accepted beat.
- Mode 1 (accumulate): sums counts over a multi-beat burst and emits one total on the last beat.
- Sits between the partial-product generator and the final adder, with valid/ready handshakes on both sides.

Parameters:
- N, 16, column bits per beat (N >= 2).
- ACC_W, 16, output/accumulator width; must be >= CW = clog2(N+2).
- PIPE, 1, internal register stages before the final stage (legal values 1 or 2).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat this cycle
- in_bits  in  N  column bits to count
- in_carry  in  1  extra single bit added to the beat count
- in_mode  in  1  0 = single, 1 = accumulate (sampled on first beat of a burst)
- in_last  in  1  last beat of an accumulate burst
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_count  out  ACC_W  result count
- out_ovf  out  1  result saturated

Behaviour:
- Clocking and reset: one clock, clk; reset is asynchronous and active-high, rst.
- Reset values: out_valid=0, out_count=0, out_ovf=0, all pipeline valid bits 0, accumulator 0, FSM=IDLE. in_ready=0 while rst is high.
- Transfer: a beat transfers when in_valid && in_ready. A result transfers when out_valid && out_ready.
- Global enable: en = !out_valid || out_ready; in_ready = en && !rst. All stages advance only when en. With en=0, every register, including out_count and out_ovf, holds.
- Stage S1: in_bits is zero-padded to G*5 bits, G = ceil(N/5). Each 5-bit group feeds a ones_count5 instance (3-bit count). S1 registers the G group counts, in_carry, mode and last, plus a valid bit.
- Stage S2: present only when PIPE=2. It pipelines the S1 contents unchanged and carries its own valid bit.
- Final stage: beat count = sum of group counts + carry (CW bits). It then accumulates and loads the output register.
- Latency: a mode-0 beat accepted at cycle t gives out_valid at t+PIPE+1, with no stalls.
- Throughput: one beat per cycle when out_ready is held at 1.
- FSM in the final stage, states IDLE and ACCUM, acting only on a valid final-stage beat:
  - IDLE, mode 0: out_count = beat count, out_ovf=0, out_valid=1; stay IDLE.
  - IDLE, mode 1, last=1: emit beat count (single-beat burst); stay IDLE.
  - IDLE, mode 1, last=0: acc = beat count; out_valid=0; go to ACCUM.
  - ACCUM: the in_mode of every beat is ignored. acc = acc + beat count (saturating). On last=1, emit acc+count and ovf, clear acc and ovf, go to IDLE. Otherwise out_valid=0.
- If en=1 and no beat is emitted, out_valid clears to 0 on that edge.
- Saturation: if the sum exceeds 2^ACC_W-1, acc is held at all-ones and a sticky ovf is set for the burst. out_ovf reflects it on the emitted result. A mode-0 result never overflows, given ACC_W >= CW.
- Boundaries:
  - Bits at positions >= N never count.
  - in_carry counts even when in_bits=0.
  - in_last is ignored in mode 0 / IDLE single beats.
  - A gap (in_valid=0) inside a burst does not close the burst.
  - Reset mid-burst discards the partial sum and all in-flight beats.

Decomposition:
- Package column_count_pkg:
  - GROUP_W=5
  - clog2 function
  - state enum {IDLE, ACCUM}
  - derived constants G and CW
- Sub-module ones_count5: 5 inputs, 3-bit count output, purely combinational, instantiated G times.
- Everything else (pipeline registers, FSM, accumulator, handshake) is in the top module.

Test Plan:
- N=16, PIPE=1, out_ready=1; single beat in_bits=16'hFFFF, carry=1, mode 0 -> out_count=17 at t+2, out_ovf=0.
- Back-to-back mode-0 beats 16'h0000, 16'h00FF, 16'hAAAA (carry 0) -> counts 0, 8, 8 on consecutive cycles; in_ready stays 1.
- Same stream with out_ready=0 for 3 cycles once out_valid rises -> in_ready=0, out_count held at 0; after release, 8 then 8, with no loss or duplication.
- Mode 1 burst 16'h000F, 16'h00F0, 16'h0F00 (last on third, one idle gap between beats 1 and 2) -> exactly one result, out_count=12, no out_valid on the first two beats.
- ACC_W=5; mode-1 burst of three 16'hFFFF beats -> out_count=31, out_ovf=1. Following mode-0 beat 16'h0001 -> out_count=1, out_ovf=0.
- Assert rst after two beats of an open burst -> outputs return to 0 immediately. After release, mode-0 beat 16'h0003 with carry 1 -> out_count=3.

Source files
------------

// File: rtl/column_count_pkg.sv
// Shared constants, state type and sizing helpers
// for the pipelined column ones counter.
package column_count_pkg;

  localparam int GROUP_W = 5;

  typedef enum logic {
    IDLE,
    ACCUM
  } state_e;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

  function automatic int num_groups(input int n);
    return (n + GROUP_W - 1) / GROUP_W;
  endfunction

  // beat count spans 0..N+1 (all bits plus carry)
  function automatic int count_w(input int n);
    return clog2(n + 2);
  endfunction

  localparam int DEF_N  = 16;
  localparam int DEF_G  = num_groups(DEF_N);
  localparam int DEF_CW = count_w(DEF_N);

endpackage

// File: rtl/column_count_accum_ones_count5.sv
// Five-input ones counter, the leaf of the
// column reduction tree.
module ones_count5 (
  input  logic [4:0] bits_i,
  output logic [2:0] cnt_o
);

  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < 5; i++) begin
      cnt_o = cnt_o + {2'b00, bits_i[i]};
    end
  end

endmodule

// File: rtl/column_count_accum.sv
// Pipelined column ones counter with optional
// burst accumulation and saturating total.
module column_count_accum
  import column_count_pkg::*;
#(
  parameter int N     = 16,
  parameter int ACC_W = 16,
  parameter int PIPE  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_bits,
  input  logic             in_carry,
  input  logic             in_mode,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_count,
  output logic             out_ovf
);

  localparam int G   = num_groups(N);
  localparam int CW  = count_w(N);
  localparam int PW  = G * GROUP_W;
  localparam int AW1 = ACC_W + 1;

  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en && !rst;

  logic [PW-1:0] padded;
  always_comb begin
    padded = '0;
    padded[N-1:0] = in_bits;
  end

  logic [G-1:0][2:0] grp_cnt;
  for (genvar g = 0; g < G; g++) begin : g_grp
    ones_count5 u_cnt (
      .bits_i (padded[g*GROUP_W +: GROUP_W]),
      .cnt_o  (grp_cnt[g])
    );
  end

  logic [G-1:0][2:0] s1_cnt_q;
  logic s1_valid_q, s1_carry_q;
  logic s1_mode_q, s1_last_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_cnt_q   <= '0;
      s1_carry_q <= 1'b0;
      s1_mode_q  <= 1'b0;
      s1_last_q  <= 1'b0;
    end else if (en) begin
      s1_valid_q <= in_valid;
      s1_cnt_q   <= grp_cnt;
      s1_carry_q <= in_carry;
      s1_mode_q  <= in_mode;
      s1_last_q  <= in_last;
    end
  end

  logic [G-1:0][2:0] f_cnt;
  logic f_valid, f_carry;
  logic f_mode, f_last;

  if (PIPE == 2) begin : g_s2
    logic [G-1:0][2:0] s2_cnt_q;
    logic s2_valid_q, s2_carry_q;
    logic s2_mode_q, s2_last_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s2_valid_q <= 1'b0;
        s2_cnt_q   <= '0;
        s2_carry_q <= 1'b0;
        s2_mode_q  <= 1'b0;
        s2_last_q  <= 1'b0;
      end else if (en) begin
        s2_valid_q <= s1_valid_q;
        s2_cnt_q   <= s1_cnt_q;
        s2_carry_q <= s1_carry_q;
        s2_mode_q  <= s1_mode_q;
        s2_last_q  <= s1_last_q;
      end
    end

    assign f_valid = s2_valid_q;
    assign f_cnt   = s2_cnt_q;
    assign f_carry = s2_carry_q;
    assign f_mode  = s2_mode_q;
    assign f_last  = s2_last_q;
  end else begin : g_s1
    assign f_valid = s1_valid_q;
    assign f_cnt   = s1_cnt_q;
    assign f_carry = s1_carry_q;
    assign f_mode  = s1_mode_q;
    assign f_last  = s1_last_q;
  end

  logic [CW-1:0] beat_cnt;
  always_comb begin
    beat_cnt = CW'(f_carry);
    for (int g = 0; g < G; g++) begin
      beat_cnt = beat_cnt + CW'(f_cnt[g]);
    end
  end

  state_e state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic ovf_q, ovf_d;
  logic ov_q, ov_d;
  logic [ACC_W-1:0] oc_q, oc_d;
  logic oo_q, oo_d;

  logic [ACC_W-1:0] beat_ext;
  logic [AW1-1:0] sum;
  logic sat;
  logic [ACC_W-1:0] acc_sat;

  assign beat_ext = ACC_W'(beat_cnt);
  assign sum      = {1'b0, acc_q} + AW1'(beat_cnt);
  assign sat      = sum[ACC_W];
  assign acc_sat  = sat ? '1 : sum[ACC_W-1:0];

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    ov_d    = 1'b0;
    oc_d    = oc_q;
    oo_d    = oo_q;
    if (f_valid) begin
      unique case (state_q)
        IDLE: begin
          if (!f_mode || f_last) begin
            ov_d = 1'b1;
            oc_d = beat_ext;
            oo_d = 1'b0;
          end else begin
            acc_d   = beat_ext;
            ovf_d   = 1'b0;
            state_d = ACCUM;
          end
        end
        ACCUM: begin
          if (f_last) begin
            ov_d    = 1'b1;
            oc_d    = acc_sat;
            oo_d    = ovf_q | sat;
            acc_d   = '0;
            ovf_d   = 1'b0;
            state_d = IDLE;
          end else begin
            acc_d = acc_sat;
            ovf_d = ovf_q | sat;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      ov_q    <= 1'b0;
      oc_q    <= '0;
      oo_q    <= 1'b0;
    end else if (en) begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      ov_q    <= ov_d;
      oc_q    <= oc_d;
      oo_q    <= oo_d;
    end
  end

  assign out_valid = ov_q;
  assign out_count = oc_q;
  assign out_ovf   = oo_q;

endmodule

// File: tb/tb_column_count_accum.sv
// Directed bench: one 16-bit and one 5-bit
// accumulator instance share the stimulus.
module tb_column_count_accum;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_bits = '0;
  logic        in_carry = 1'b0;
  logic        in_mode = 1'b0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b1;

  logic        in_ready, out_valid, out_ovf;
  logic [15:0] out_count;
  logic        in_ready5, out_valid5, out_ovf5;
  logic [4:0]  out_count5;

  always #5 clk = ~clk;

  column_count_accum #(.N(16), .ACC_W(16), .PIPE(1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_bits(in_bits), .in_carry(in_carry),
    .in_mode(in_mode), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_count(out_count), .out_ovf(out_ovf)
  );

  column_count_accum #(.N(16), .ACC_W(5), .PIPE(1)) dut5 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready5),
    .in_bits(in_bits), .in_carry(in_carry),
    .in_mode(in_mode), .in_last(in_last),
    .out_valid(out_valid5), .out_ready(out_ready),
    .out_count(out_count5), .out_ovf(out_ovf5)
  );

  typedef struct {
    int cnt;
    int ovf;
    int cyc;
  } res_t;

  res_t q16[$];
  res_t q5[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    #3;
    if (!rst && out_valid && out_ready)
      q16.push_back('{int'(out_count), int'(out_ovf), cyc});
    if (!rst && out_valid5 && out_ready)
      q5.push_back('{int'(out_count5), int'(out_ovf5), cyc});
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic exp16(input string tag, input int i,
                       input int cnt, input int ovf);
    if (q16.size() > i) begin
      check({tag, "_cnt"}, q16[i].cnt, cnt);
      check({tag, "_ovf"}, q16[i].ovf, ovf);
    end else begin
      check({tag, "_missing"}, q16.size(), i + 1);
    end
  endtask

  task automatic exp5(input string tag, input int i,
                      input int cnt, input int ovf);
    if (q5.size() > i) begin
      check({tag, "_cnt"}, q5[i].cnt, cnt);
      check({tag, "_ovf"}, q5[i].ovf, ovf);
    end else begin
      check({tag, "_missing"}, q5.size(), i + 1);
    end
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
    in_bits  = '0;
    in_carry = 1'b0;
    in_mode  = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // called at posedge+1; returns at posedge+1 after the accept edge
  task automatic send(input logic [15:0] b, input logic c,
                      input logic m, input logic l,
                      output int acc_cyc);
    int  n;
    bit  ok;
    in_valid = 1'b1;
    in_bits  = b;
    in_carry = c;
    in_mode  = m;
    in_last  = l;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 50) begin
      @(negedge clk);
      #2;
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) check("send_timeout", 0, 1);
    acc_cyc = cyc;
    idle_in();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_in();
    out_ready = 1'b1;
    @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_count", out_count, 0);
    check("rst_ovf", out_ovf, 0);
    check("rst_ready", in_ready, 0);
    step(1);
    rst = 1'b0;
    q16.delete();
    q5.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int a0, a1, a2;
    idle_in();
    step(2);
    do_reset();

    // single beat, full column plus carry; last ignored in mode 0
    send(16'hFFFF, 1'b1, 1'b0, 1'b1, a0);
    step(4);
    check("t1_n", q16.size(), 1);
    exp16("t1", 0, 17, 0);
    if (q16.size() > 0) check("t1_lat", q16[0].cyc, a0 + 1);
    q16.delete();
    q5.delete();
    send(16'h0000, 1'b1, 1'b0, 1'b0, a0);
    step(4);
    exp16("t1_carry", 0, 1, 0);

    // back-to-back single beats
    q16.delete();
    q5.delete();
    send(16'h0000, 1'b0, 1'b0, 1'b0, a0);
    send(16'h00FF, 1'b0, 1'b0, 1'b0, a1);
    send(16'hAAAA, 1'b0, 1'b0, 1'b0, a2);
    check("t2_tput1", a1, a0 + 1);
    check("t2_tput2", a2, a1 + 1);
    step(4);
    check("t2_n", q16.size(), 3);
    exp16("t2_0", 0, 0, 0);
    exp16("t2_1", 1, 8, 0);
    exp16("t2_2", 2, 8, 0);
    if (q16.size() > 2) check("t2_cyc", q16[2].cyc, a0 + 3);

    // backpressure once the first result is up
    q16.delete();
    q5.delete();
    fork
      begin
        send(16'h0000, 1'b0, 1'b0, 1'b0, a0);
        send(16'h00FF, 1'b0, 1'b0, 1'b0, a1);
        send(16'hAAAA, 1'b0, 1'b0, 1'b0, a2);
      end
      begin
        int n;
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!out_valid && n < 30);
        check("t3_rise", out_valid, 1);
        out_ready = 1'b0;
        repeat (3) begin
          @(posedge clk);
          @(negedge clk);
          #1;
          check("t3_ready", in_ready, 0);
          check("t3_hold", out_count, 0);
          check("t3_valid", out_valid, 1);
        end
        out_ready = 1'b1;
      end
    join
    step(5);
    check("t3_n", q16.size(), 3);
    exp16("t3_0", 0, 0, 0);
    exp16("t3_1", 1, 8, 0);
    exp16("t3_2", 2, 8, 0);

    // accumulate burst with an idle gap
    q16.delete();
    q5.delete();
    send(16'h000F, 1'b0, 1'b1, 1'b0, a0);
    step(1);
    send(16'h00F0, 1'b0, 1'b1, 1'b0, a1);
    send(16'h0F00, 1'b0, 1'b1, 1'b1, a2);
    step(4);
    check("t4_n", q16.size(), 1);
    exp16("t4", 0, 12, 0);

    // saturation on the narrow instance
    do_reset();
    send(16'hFFFF, 1'b0, 1'b1, 1'b0, a0);
    send(16'hFFFF, 1'b0, 1'b1, 1'b0, a1);
    send(16'hFFFF, 1'b0, 1'b1, 1'b1, a2);
    step(4);
    check("t5_n", q5.size(), 1);
    exp5("t5_sat", 0, 31, 1);
    exp16("t5_wide", 0, 48, 0);
    q16.delete();
    q5.delete();
    send(16'h0001, 1'b0, 1'b0, 1'b0, a0);
    step(4);
    exp5("t5_after", 0, 1, 0);

    // reset in the middle of an open burst
    q16.delete();
    q5.delete();
    send(16'hFFFF, 1'b0, 1'b1, 1'b0, a0);
    send(16'hFFFF, 1'b0, 1'b1, 1'b0, a1);
    rst = 1'b1;
    #1;
    check("t6_valid", out_valid, 0);
    check("t6_count", out_count, 0);
    check("t6_count5", out_count5, 0);
    check("t6_ready", in_ready, 0);
    step(2);
    rst = 1'b0;
    q16.delete();
    q5.delete();
    send(16'h0003, 1'b1, 1'b0, 1'b0, a0);
    step(4);
    check("t6_n", q16.size(), 1);
    exp16("t6", 0, 3, 0);
    exp5("t6_5", 0, 3, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
